// File: rtl/ysyx_22041412_mdu_ctrl.sv
// Iterative RV64M multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with valid/ready handshakes on both sides.
module ysyx_22041412_mdu_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            is_w,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned HW = XLEN / 2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          f3_q;
  logic                w_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     result_q;
  logic                out_valid_q;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HW{v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{HW{1'b0}}, v[HW-1:0]};
  endfunction

  // Operand preparation and fast-path detection for the op presented at the input.
  logic            sgn1, sgn2, a_neg, b_neg;
  logic            illegal, div_zero, div_ovf, fast;
  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_val, fast_raw, fast_res;

  always_comb begin
    sgn1 = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    sgn2 = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    op_a = src1;
    op_b = src2;
    if (is_w) begin
      op_a = sgn1 ? sext_w(src1) : zext_w(src1);
      op_b = sgn2 ? sext_w(src2) : zext_w(src2);
    end
    a_neg = sgn1 & op_a[XLEN-1];
    b_neg = sgn2 & op_b[XLEN-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (is_w) min_val = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
    illegal  = is_w & ~func3[2] & (func3[1:0] != 2'b00);
    div_zero = func3[2] & (op_b == '0);
    div_ovf  = func3[2] & ~func3[0] & (op_a == min_val) & (op_b == '1);
    fast     = illegal | div_zero | div_ovf;
    if (illegal)       fast_raw = '0;
    else if (div_zero) fast_raw = func3[1] ? op_a : '1;
    else               fast_raw = func3[1] ? '0 : op_a;
    fast_res = is_w ? sext_w(fast_raw) : fast_raw;
  end

  // One iteration step, plus the sign-fixed result should this be the final step.
  logic [2*XLEN-1:0] acc_n, mcand_n, prod;
  logic [XLEN-1:0]   mplier_n, quo, rem, res_raw, res_fix;
  logic [XLEN:0]     rem_sh, diff;
  logic              last;

  always_comb begin
    rem_sh = '0;
    diff   = '0;
    if (!f3_q[2]) begin
      acc_n    = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mplier_n = mplier_q >> 1;
      mcand_n  = mcand_q << 1;
    end else begin
      rem_sh   = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
      diff     = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
      acc_n    = {{XLEN{1'b0}}, diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]};
      mplier_n = {mplier_q[XLEN-2:0], ~diff[XLEN]};
      mcand_n  = mcand_q;
    end
    prod = neg_q ? -acc_n : acc_n;
    quo  = neg_q ? -mplier_n : mplier_n;
    rem  = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    unique case (f3_q)
      3'b000:                 res_raw = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_raw = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_raw = quo;
      default:                res_raw = rem;
    endcase
    res_fix = w_q ? sext_w(res_raw) : res_raw;
    last    = (cnt_q == (w_q ? CW'(HW - 1) : CW'(XLEN - 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      f3_q        <= '0;
      w_q         <= 1'b0;
      neg_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && !flush) begin
            f3_q  <= func3;
            w_q   <= is_w;
            neg_q <= (func3[2] & func3[1]) ? a_neg : (a_neg ^ b_neg);
            cnt_q <= '0;
            acc_q <= '0;
            if (func3[2]) begin
              mcand_q  <= {{XLEN{1'b0}}, mag_b};
              // W divides only run HW steps, so the dividend starts in the top half.
              mplier_q <= is_w ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
            end else begin
              mcand_q  <= {{XLEN{1'b0}}, mag_a};
              mplier_q <= mag_b;
            end
            if (fast) begin
              state_q     <= StDone;
              result_q    <= fast_res;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end else begin
            acc_q    <= acc_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
              state_q     <= StDone;
              result_q    <= res_fix;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (flush || out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
// Directed and randomized checks of the MDU sequencer against an arithmetic reference model.
module tb_ysyx_22041412_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, is_w, flush, out_valid, out_ready, busy;
  logic [2:0]  func3;
  logic [63:0] src1, src2, result;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  ysyx_22041412_mdu_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .func3(func3),
    .is_w(is_w), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  r;
    logic [31:0]  a32, b32, r32;
    longint       sa, sb;
    int           sa32, sb32;
    sa = a; sb = b;
    a32 = a[31:0]; b32 = b[31:0];
    sa32 = a32; sb32 = b32;
    r = '0; r32 = '0; p = '0;
    if (!w) begin
      case (f)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        3'd4: r = (b == 0) ? '1 : (a == MIN64 && b == '1) ? a : 64'(sa / sb);
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: r = (b == 0) ? a : (a == MIN64 && b == '1) ? 64'd0 : 64'(sa % sb);
        default: r = (b == 0) ? a : a % b;
      endcase
      return r;
    end
    case (f)
      3'd0: r32 = a32 * b32;
      3'd1, 3'd2, 3'd3: return 64'd0;
      3'd4: r32 = (b32 == 0) ? '1 : (a32 == 32'h8000_0000 && b32 == '1) ? a32 : 32'(sa32 / sb32);
      3'd5: r32 = (b32 == 0) ? '1 : a32 / b32;
      3'd6: r32 = (b32 == 0) ? a32 : (a32 == 32'h8000_0000 && b32 == '1) ? 32'd0
                                                                        : 32'(sa32 % sb32);
      default: r32 = (b32 == 0) ? a32 : a32 % b32;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (w && f >= 3'd1 && f <= 3'd3) return 1;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hffff_ffff) : (a == MIN64 && b == '1);
    if (f[2] && (zero || (!f[0] && ovf))) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0, 1: return {$urandom, $urandom};
      2: return 64'($urandom_range(0, 20));
      3: return -64'($urandom_range(1, 20));
      4: return 64'd0;
      default: return ($urandom_range(0, 1) == 1) ? MIN64 : 64'hffff_ffff_8000_0000;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b);
    func3 = f; is_w = w; src1 = a; src2 = b;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; returns cycles since accept, accept cycle being T.
  task automatic wait_valid(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic w,
                     input logic [63:0] a, input logic [63:0] b);
    int n;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    issue(f, w, a, b);
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n), 64'(ref_lat(f, w, a, b)));
    chk({tag, "_result"}, result, ref_res(f, w, a, b));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] e;
    rst_n = 1'b0; in_valid = 1'b0; is_w = 1'b0; flush = 1'b0; out_ready = 1'b0;
    func3 = '0; src1 = '0; src2 = '0;
    tick; tick; tick;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick;

    run("mul", 3'd0, 1'b0, 64'd3, -64'd5);
    chk("mul_const", ref_res(3'd0, 1'b0, 64'd3, -64'd5), 64'hffff_ffff_ffff_fff1);
    run("mulhu", 3'd3, 1'b0, '1, '1);
    run("mulhsu", 3'd2, 1'b0, '1, 64'd2);
    run("mulh", 3'd1, 1'b0, MIN64, 64'd3);
    run("divu0", 3'd5, 1'b0, 64'd1234, 64'd0);
    run("rem0", 3'd6, 1'b0, -64'd7, 64'd0);
    run("divw_ovf", 3'd4, 1'b1, 64'h8000_0000, '1);
    run("div_ovf", 3'd4, 1'b0, MIN64, '1);
    run("remw", 3'd6, 1'b1, -64'd7, 64'd2);
    run("div", 3'd4, 1'b0, -64'd100, 64'd7);
    run("mulw", 3'd0, 1'b1, 64'h1234_5678_9abc_def0, 64'hffff_0000_0000_0003);
    run("mulhw_illegal", 3'd1, 1'b1, 64'd5, 64'd6);

    // Result hold while the consumer stalls.
    issue(3'd7, 1'b0, 64'd1000, 64'd7);
    wait_valid(n);
    e = ref_res(3'd7, 1'b0, 64'd1000, 64'd7);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, e);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // Flush mid-divide, then a fresh multiply right after.
    issue(3'd4, 1'b0, 64'd999, 64'd3);
    for (int i = 1; i < 10; i++) begin
      chk("flush_no_valid", 64'(out_valid), 64'd0);
      tick;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    run("post_flush_mul", 3'd0, 1'b0, 64'd12345, 64'd678);

    // Reset in the middle of a calculation.
    issue(3'd4, 1'b0, 64'd50, 64'd3);
    tick; tick; tick; tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 40; i++) begin
      run("rand", 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), pick(), pick());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
